// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the sample-RAM port arbiter, its requesters and the RAM port.
// The arbiter takes the slave side; requesters and the RAM model sit on the master side.
interface ram_port_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int ADDRESS_SIZE = 8,
  parameter int DATA_SIZE    = 8
);
  logic [NUM_REQ-1:0]                   req_valid;
  logic [NUM_REQ-1:0]                   req_we;
  logic [NUM_REQ-1:0]                   req_lock;
  logic [NUM_REQ-1:0][ADDRESS_SIZE-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_SIZE-1:0]    req_wdata;
  logic [NUM_REQ-1:0]                   req_ready;
  logic [NUM_REQ-1:0]                   resp_valid;
  logic [DATA_SIZE-1:0]                 resp_data;
  logic [ADDRESS_SIZE-1:0]              ram_addr;
  logic                                 ram_we;
  logic                                 ram_re;
  logic [DATA_SIZE-1:0]                 ram_w_data;
  logic [DATA_SIZE-1:0]                 ram_r_data;

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, ram_r_data,
    output req_ready, resp_valid, resp_data, ram_addr, ram_we, ram_re, ram_w_data
  );

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, ram_r_data,
    input  req_ready, resp_valid, resp_data, ram_addr, ram_we, ram_re, ram_w_data
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one sample-RAM port among NUM_REQ requesters, with
// burst locking (bounded by MAX_LOCK) and read-data routing across the 1-cycle RAM latency.
module ram_port_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDRESS_SIZE = 8,
  parameter int DATA_SIZE    = 8,
  parameter int MAX_LOCK     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_res,
  ram_port_arbiter_if.slave    bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  idx_t               rr_ptr_q,     rr_ptr_d;
  logic               lock_vld_q,   lock_vld_d;
  idx_t               lock_owner_q, lock_owner_d;
  cnt_t               lock_cnt_q,   lock_cnt_d;
  logic [NUM_REQ-1:0] rd_tag_q,     rd_tag_d;

  logic               gnt_vld;
  idx_t               gnt_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  cnt_t               cnt_inc;

  logic [NUM_REQ-1:0]      req_ready_c;
  logic [NUM_REQ-1:0]      resp_valid_c;
  logic [DATA_SIZE-1:0]    resp_data_c;
  logic [ADDRESS_SIZE-1:0] ram_addr_c;
  logic                    ram_we_c;
  logic                    ram_re_c;
  logic [DATA_SIZE-1:0]    ram_w_data_c;

  function automatic idx_t wrap_add(input idx_t base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return idx_t'(s);
  endfunction

  // State register
  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      rr_ptr_q     <= '0;
      lock_vld_q   <= 1'b0;
      lock_owner_q <= '0;
      lock_cnt_q   <= '0;
      rd_tag_q     <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_vld_q   <= lock_vld_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_tag_q     <= rd_tag_d;
    end
  end

  // A valid lock owner wins outright; otherwise first valid requester from rr_ptr upward.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (lock_vld_q && bus.req_valid[lock_owner_q]) begin
      gnt_vld = 1'b1;
      gnt_idx = lock_owner_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!gnt_vld && bus.req_valid[wrap_add(rr_ptr_q, k)]) begin
          gnt_vld = 1'b1;
          gnt_idx = wrap_add(rr_ptr_q, k);
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign gnt_oh[gi] = gnt_vld && (gnt_idx == idx_t'(gi));
  end

  // Next-state: pointer, lock bookkeeping and read tag
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_vld_d   = lock_vld_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    rd_tag_d     = '0;
    cnt_inc      = cnt_t'(1);

    if (lock_vld_q && !bus.req_valid[lock_owner_q]) begin
      lock_vld_d   = 1'b0;
      lock_owner_d = '0;
      lock_cnt_d   = '0;
    end

    if (gnt_vld) begin
      if (!bus.req_we[gnt_idx]) rd_tag_d = gnt_oh;

      if (lock_vld_q && (lock_owner_q == gnt_idx)) cnt_inc = lock_cnt_q + cnt_t'(1);

      if (bus.req_lock[gnt_idx] && (cnt_inc < cnt_t'(MAX_LOCK))) begin
        lock_vld_d   = 1'b1;
        lock_owner_d = gnt_idx;
        lock_cnt_d   = cnt_inc;
      end else begin
        // Either an unlocked transfer or a lock that just used up its MAX_LOCK budget.
        lock_vld_d   = 1'b0;
        lock_owner_d = '0;
        lock_cnt_d   = '0;
        rr_ptr_d     = wrap_add(gnt_idx, 1);
      end
    end
  end

  // Outputs are forced quiet while reset is held, even if requests are present.
  always_comb begin
    req_ready_c  = '0;
    resp_valid_c = '0;
    resp_data_c  = '0;
    ram_addr_c   = '0;
    ram_we_c     = 1'b0;
    ram_re_c     = 1'b0;
    ram_w_data_c = '0;
    if (i_res) begin
      if (gnt_vld) begin
        req_ready_c = gnt_oh;
        ram_addr_c  = bus.req_addr[gnt_idx];
        ram_we_c    = bus.req_we[gnt_idx];
        ram_re_c    = !bus.req_we[gnt_idx];
        if (bus.req_we[gnt_idx]) ram_w_data_c = bus.req_wdata[gnt_idx];
      end
      resp_valid_c = rd_tag_q;
      if (|rd_tag_q) resp_data_c = bus.ram_r_data;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_data  = resp_data_c;
  assign bus.ram_addr   = ram_addr_c;
  assign bus.ram_we     = ram_we_c;
  assign bus.ram_re     = ram_re_c;
  assign bus.ram_w_data = ram_w_data_c;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small registered-read RAM model on the port.
module tb_ram_port_arbiter;
  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int ML = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.NUM_REQ(NR), .ADDRESS_SIZE(AW), .DATA_SIZE(DW)) bus ();

  ram_port_arbiter #(.NUM_REQ(NR), .ADDRESS_SIZE(AW), .DATA_SIZE(DW), .MAX_LOCK(ML)) dut (
    .i_clk (clk),
    .i_res (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rd_q;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_w_data;
    if (bus.ram_re) rd_q <= mem[bus.ram_addr];
  end
  assign bus.ram_r_data = rd_q;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic set_req(input int r, input logic we, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[r] = 1'b1;
    bus.req_we[r]    = we;
    bus.req_lock[r]  = lk;
    bus.req_addr[r]  = a;
    bus.req_wdata[r] = d;
  endtask

  // One clock cycle: check grant and response against expectations, then advance.
  task automatic cyc(input string tag, input logic [3:0] rdy, input logic [3:0] rv,
                     input logic [7:0] rd);
    #1;
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'(rdy));
    chk({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'(rv));
    if (rv != 4'b0000) chk({tag, ".resp_data"}, 32'(bus.resp_data), 32'(rd));
    $display("cycle %s: ready=%b resp_valid=%b resp_data=%02h", tag, bus.req_ready,
             bus.resp_valid, bus.resp_data);
    tick();
  endtask

  initial begin
    idle();
    set_req(0, 1'b0, 1'b0, 8'h10, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 32'(bus.req_ready), 32'h0);
    chk("rst.resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst.resp_data", 32'(bus.resp_data), 32'h0);
    chk("rst.ram_re", 32'(bus.ram_re), 32'h0);
    chk("rst.ram_we", 32'(bus.ram_we), 32'h0);
    chk("rst.ram_addr", 32'(bus.ram_addr), 32'h0);
    rst_n = 1'b1;

    // Single requester: write then read back
    idle(); set_req(0, 1'b1, 1'b0, 8'h10, 8'hA5);
    #1;
    chk("t1_wr.ram_we", 32'(bus.ram_we), 32'h1);
    chk("t1_wr.ram_re", 32'(bus.ram_re), 32'h0);
    chk("t1_wr.ram_addr", 32'(bus.ram_addr), 32'h10);
    chk("t1_wr.ram_w_data", 32'(bus.ram_w_data), 32'hA5);
    cyc("t1_wr", 4'b0001, 4'b0000, 8'h00);
    idle(); set_req(0, 1'b0, 1'b0, 8'h10, 8'h5A);
    #1;
    chk("t1_rd.ram_re", 32'(bus.ram_re), 32'h1);
    chk("t1_rd.ram_w_data", 32'(bus.ram_w_data), 32'h0);
    cyc("t1_rd", 4'b0001, 4'b0000, 8'h00);
    idle(); cyc("t1_resp", 4'b0000, 4'b0001, 8'hA5);
    idle(); cyc("t1_idle", 4'b0000, 4'b0000, 8'h00);

    // Preload one word per requester; last grant to req 3 leaves rr_ptr at 0
    idle(); set_req(1, 1'b1, 1'b0, 8'h21, 8'h11); cyc("pl1", 4'b0010, 4'b0000, 8'h00);
    idle(); set_req(2, 1'b1, 1'b0, 8'h22, 8'h22); cyc("pl2", 4'b0100, 4'b0000, 8'h00);
    idle(); set_req(0, 1'b1, 1'b0, 8'h20, 8'h44); cyc("pl0", 4'b0001, 4'b0000, 8'h00);
    idle(); set_req(3, 1'b1, 1'b0, 8'h23, 8'h33); cyc("pl3", 4'b1000, 4'b0000, 8'h00);

    // Fairness: all four read continuously
    idle();
    for (int r = 0; r < NR; r++) set_req(r, 1'b0, 1'b0, 8'(8'h20 + r), 8'h00);
    cyc("rr0", 4'b0001, 4'b0000, 8'h00);
    #1;
    chk("rr1.ram_addr", 32'(bus.ram_addr), 32'h21);
    cyc("rr1", 4'b0010, 4'b0001, 8'h44);
    cyc("rr2", 4'b0100, 4'b0010, 8'h11);
    cyc("rr3", 4'b1000, 4'b0100, 8'h22);
    cyc("rr4", 4'b0001, 4'b1000, 8'h33);
    idle(); cyc("rr_tail", 4'b0000, 4'b0001, 8'h44);

    // Lock burst by req 2 while reqs 0 and 1 wait
    idle(); set_req(1, 1'b0, 1'b0, 8'h21, 8'h00); cyc("lk_pre", 4'b0010, 4'b0000, 8'h00);
    idle();
    set_req(0, 1'b0, 1'b0, 8'h20, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h21, 8'h00);
    set_req(2, 1'b0, 1'b1, 8'h22, 8'h00);
    cyc("lk_b0", 4'b0100, 4'b0010, 8'h11);
    for (int i = 1; i < 4; i++) cyc($sformatf("lk_b%0d", i), 4'b0100, 4'b0100, 8'h22);
    bus.req_lock[2] = 1'b0;
    cyc("lk_b4", 4'b0100, 4'b0100, 8'h22);
    bus.req_valid[2] = 1'b0;
    cyc("lk_after", 4'b0001, 4'b0100, 8'h22);
    idle(); cyc("lk_tail", 4'b0000, 4'b0001, 8'h44);

    // Lock timeout: req 1 holds lock, forced release after MAX_LOCK grants
    idle();
    set_req(1, 1'b0, 1'b1, 8'h21, 8'h00);
    set_req(2, 1'b0, 1'b0, 8'h22, 8'h00);
    cyc("to_0", 4'b0010, 4'b0000, 8'h00);
    for (int i = 1; i < ML; i++) cyc($sformatf("to_%0d", i), 4'b0010, 4'b0010, 8'h11);
    cyc("to_rel", 4'b0100, 4'b0010, 8'h11);
    cyc("to_resume", 4'b0010, 4'b0100, 8'h22);
    idle(); cyc("to_tail", 4'b0000, 4'b0010, 8'h11);

    // Reset during the response cycle of a read
    idle(); set_req(0, 1'b0, 1'b0, 8'h20, 8'h00); cyc("rst_rd", 4'b0001, 4'b0000, 8'h00);
    rst_n = 1'b0;
    idle(); set_req(3, 1'b1, 1'b0, 8'h30, 8'hFF);
    #1;
    chk("rst_mid.resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_mid.resp_data", 32'(bus.resp_data), 32'h0);
    chk("rst_mid.ready", 32'(bus.req_ready), 32'h0);
    chk("rst_mid.ram_we", 32'(bus.ram_we), 32'h0);
    chk("rst_mid.ram_addr", 32'(bus.ram_addr), 32'h0);
    chk("rst_mid.ram_w_data", 32'(bus.ram_w_data), 32'h0);
    tick();
    rst_n = 1'b1;
    idle();
    set_req(0, 1'b0, 1'b0, 8'h20, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h21, 8'h00);
    cyc("rst_ptr", 4'b0001, 4'b0000, 8'h00);
    idle(); cyc("rst_resp", 4'b0000, 4'b0001, 8'h44);

    // Write by req 0 followed immediately by read of the same address by req 1
    idle(); set_req(0, 1'b1, 1'b0, 8'h07, 8'h3C); cyc("mx_wr", 4'b0001, 4'b0000, 8'h00);
    idle(); set_req(1, 1'b0, 1'b0, 8'h07, 8'h00); cyc("mx_rd", 4'b0010, 4'b0000, 8'h00);
    idle(); cyc("mx_resp", 4'b0000, 4'b0010, 8'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
